instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multicycle fetch/decode/execute sequencer for the 4-bit-opcode accumulator datapath (A and B registers, 3-bit-select ALU, unified memory).
- Owns PC and IR.
- Drives the memory request/ready handshake and times the loadA, loadB, aluSel and memWrite strobes so each instruction completes in a fixed state sequence.
- Sits between the program/data memory and the register/ALU datapath.

Parameters:
- ADDR_W, 4, PC and operand-address width; instruction word = {opcode[3:0], operand[ADDR_W-1:0]}
- DATA_W, 8, memory word width; must equal 4+ADDR_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution from current PC; honoured only in IDLE
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write (STORE), 0 = read
- mem_addr  out  ADDR_W  transaction address
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1
- mem_ready  in  1  completes current transaction this cycle; may be asserted in the same cycle as mem_req; ignored when mem_req=0
- loadA  out  1  A register load strobe
- a_src  out  1  A input select: 0 = B register, 1 = ALU result
- loadB  out  1  B captures mem_rdata
- aluSel  out  3  ADD 000, SUB 001, AND 010, OR 011, NOT 100
- memWrite  out  1  equals mem_req & mem_we; A supplies write data
- pc  out  ADDR_W  program counter
- ir  out  DATA_W  instruction register
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on an undefined opcode

Behaviour:
- Reset (async, any state): state=IDLE; pc=0, ir=0, illegal=0. All strobes 0, aluSel=000, halted=0.
- Outputs are decoded from state and ir. Exception: loadB and retire also qualify on mem_ready as noted below.
- Opcodes: NOP 0000, LOAD 0001, STORE 0010, ADD 0011, SUB 0100, AND 0101, OR 0110, NOT 0111, HALT 1111. Codes 1000-1110 are undefined.
- IDLE: wait for start=1, then go to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold while mem_ready=0. On mem_ready: ir<=mem_rdata; pc<=pc+1 mod 2^ADDR_W (wraps 1111->0000); go to DECODE.
- DECODE (1 cycle): branch on opcode.
  - NOP: retire=1; go to FETCH.
  - HALT: retire=1; go to HALT.
  - LOAD/ADD/SUB/AND/OR: go to OPERAND.
  - NOT: go to EXEC.
  - STORE: go to STORE.
  - Undefined: illegal<=1, retire=1, treated as NOP; go to FETCH.
- OPERAND: mem_req=1, mem_we=0, mem_addr=ir operand field. Hold while mem_ready=0. On mem_ready: loadB=1 that cycle; go to EXEC.
- EXEC (1 cycle): loadA=1, retire=1; go to FETCH.
  - LOAD: a_src=0.
  - ALU ops: a_src=1, aluSel per the code table.
  - NOT: aluSel=100, B unused.
- STORE: mem_req=1, mem_we=1, memWrite=1, mem_addr=operand. Hold while mem_ready=0. On mem_ready: retire=1; go to FETCH.
- HALT: halted=1, no requests. start is ignored; only rst exits.
- Request stability: mem_addr and mem_we stay stable while mem_req=1 and mem_ready=0. mem_req is never dropped before mem_ready.
- Latency with zero-wait memory (mem_ready tied 1):
  - ALU op/LOAD: 4 cycles.
  - NOT and STORE: 3 cycles.
  - NOP/HALT: 2 cycles.
  - Each mem_ready wait cycle adds 1.
- start while not in IDLE: no effect.
- Reset mid-transaction: mem_req drops immediately and the in-flight instruction is abandoned. pc returns to 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_NOP … OP_HALT);
  - ALU select constants (ALU_ADD … ALU_NOT);
  - A_SRC_B / A_SRC_ALU;
  - state encoding IDLE, FETCH, DECODE, OPERAND, EXEC, STORE, HALT.
- One combinational sub-module, seq_decode: opcode -> {needs_operand, is_store, is_halt, is_nop, illegal, aluSel}. It is instantiated in DECODE and EXEC.

Test Plan:
- Reset then start, memory[0]=0x15 (LOAD 5), memory[5]=0x2A, zero-wait: loadB in cycle 3, loadA with a_src=0 in cycle 4, retire in cycle 4, pc=1.
- Program ADD 6 (0x36) with mem_ready delayed 2 cycles per request: mem_addr held at 0 then 6 during waits; loadA with aluSel=000, a_src=1 exactly once; total 8 cycles.
- STORE 9 (0x29): mem_req=1, mem_we=1, memWrite=1, mem_addr=9 until ready; no loadA or loadB; retire on the ready cycle.
- NOT (0x70), then opcode 0x9x, then HALT (0xF0):
  - NOT: 3 cycles, aluSel=100.
  - 0x9x: illegal latches 1, no strobes.
  - HALT: halted=1; later start pulses ignored; mem_req stays 0.
- pc=15 fetching NOP: pc wraps to 0.
- rst asserted mid-OPERAND wait: mem_req falls asynchronously; pc=0, ir=0, state IDLE; no loadB.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU select and sequencer state definitions
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;

  localparam logic A_SRC_B   = 1'b0;
  localparam logic A_SRC_ALU = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    EXEC,
    STORE,
    HALT
  } state_t;

  typedef struct packed {
    logic       needs_operand;
    logic       is_store;
    logic       is_halt;
    logic       is_nop;
    logic       illegal;
    logic [2:0] alu_sel;
  } dec_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - memory request/ready bus between sequencer and memory
interface instr_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode classifier for the sequencer
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:   dec.is_nop = 1'b1;
      OP_LOAD:  dec.needs_operand = 1'b1;
      OP_STORE: dec.is_store = 1'b1;
      OP_ADD: begin
        dec.needs_operand = 1'b1;
        dec.alu_sel       = ALU_ADD;
      end
      OP_SUB: begin
        dec.needs_operand = 1'b1;
        dec.alu_sel       = ALU_SUB;
      end
      OP_AND: begin
        dec.needs_operand = 1'b1;
        dec.alu_sel       = ALU_AND;
      end
      OP_OR: begin
        dec.needs_operand = 1'b1;
        dec.alu_sel       = ALU_OR;
      end
      OP_NOT:  dec.alu_sel = ALU_NOT;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multicycle fetch/decode/execute sequencer owning PC and IR
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_sequencer_if.master mem,
  output logic              loadA,
  output logic              a_src,
  output logic              loadB,
  output logic [2:0]        aluSel,
  output logic              memWrite,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  dec_t              dec;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];

  seq_decode u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH: begin
          if (mem.mem_ready) begin
            ir    <= mem.mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          // Undefined opcodes retire as NOPs but leave a sticky flag behind
          if (dec.illegal) begin
            illegal <= 1'b1;
            state   <= FETCH;
          end else if (dec.is_nop)        state <= FETCH;
          else if (dec.is_halt)           state <= HALT;
          else if (dec.is_store)          state <= STORE;
          else if (dec.needs_operand)     state <= OPERAND;
          else                            state <= EXEC;
        end
        OPERAND: if (mem.mem_ready) state <= EXEC;
        EXEC:    state <= FETCH;
        STORE:   if (mem.mem_ready) state <= FETCH;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the registered state; only loadB/retire look at mem_ready
  always_comb begin
    req    = 1'b0;
    we     = 1'b0;
    addr   = pc;
    loadA  = 1'b0;
    a_src  = A_SRC_B;
    loadB  = 1'b0;
    aluSel = ALU_ADD;
    retire = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH: begin
        req  = 1'b1;
        addr = pc;
      end
      DECODE: retire = dec.is_nop | dec.is_halt | dec.illegal;
      OPERAND: begin
        req   = 1'b1;
        addr  = operand;
        loadB = mem.mem_ready;
      end
      EXEC: begin
        loadA  = 1'b1;
        retire = 1'b1;
        a_src  = (opcode == OP_LOAD) ? A_SRC_B : A_SRC_ALU;
        aluSel = dec.alu_sel;
      end
      STORE: begin
        req    = 1'b1;
        we     = 1'b1;
        addr   = operand;
        retire = mem.mem_ready;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.mem_addr = addr;
  assign memWrite     = req & we;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench with ISA-level reference model
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       loadA, a_src, loadB, memWrite, retire, halted, illegal;
  logic [2:0] aluSel;
  logic [3:0] pc;
  logic [7:0] ir;

  always #5 clk = ~clk;

  instr_sequencer_if #(.ADDR_W(4), .DATA_W(8)) mem_bus ();

  instr_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem      (mem_bus.master),
    .loadA    (loadA),
    .a_src    (a_src),
    .loadB    (loadB),
    .aluSel   (aluSel),
    .memWrite (memWrite),
    .pc       (pc),
    .ir       (ir),
    .retire   (retire),
    .halted   (halted),
    .illegal  (illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment: memory with random wait states plus the A/B/ALU datapath
  logic [7:0] mem [16];
  logic [7:0] init_mem [16];
  logic [7:0] a_reg, b_reg, init_a;
  int         wait_left, wait_min, wait_max;
  logic       do_load, stall_en;
  logic [3:0] stall_addr;

  assign mem_bus.mem_rdata = mem[mem_bus.mem_addr];
  assign mem_bus.mem_ready = mem_bus.mem_req && (wait_left == 0) &&
                             !(stall_en && mem_bus.mem_addr == stall_addr);

  function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (do_load) begin
      mem       <= init_mem;
      a_reg     <= init_a;
      b_reg     <= 8'h00;
      wait_left <= int'($urandom_range(32'(wait_max), 32'(wait_min)));
    end else begin
      if (loadB) b_reg <= mem_bus.mem_rdata;
      if (loadA) a_reg <= a_src ? alu(aluSel, a_reg, b_reg) : b_reg;
      if (memWrite && mem_bus.mem_ready) mem[mem_bus.mem_addr] <= a_reg;
      if (mem_bus.mem_req)
        wait_left <= mem_bus.mem_ready ? int'($urandom_range(32'(wait_max), 32'(wait_min)))
                                       : ((wait_left > 0) ? wait_left - 1 : 0);
    end
  end

  // Instruction-set reference model
  logic [7:0] ref_mem [16];
  logic [7:0] ref_a;
  logic [3:0] ref_pc;
  logic       ref_illegal;

  task automatic ref_step(output int op);
    logic [7:0] instr;
    logic [3:0] x;
    instr  = ref_mem[ref_pc];
    op     = int'(instr[7:4]);
    x      = instr[3:0];
    ref_pc = ref_pc + 4'd1;
    case (op)
      0, 15: ;
      1: ref_a = ref_mem[x];
      2: ref_mem[x] = ref_a;
      3: ref_a = ref_a + ref_mem[x];
      4: ref_a = ref_a - ref_mem[x];
      5: ref_a = ref_a & ref_mem[x];
      6: ref_a = ref_a | ref_mem[x];
      7: ref_a = ~ref_a;
      default: ref_illegal = 1'b1;
    endcase
  endtask

  function automatic int base_lat(input int op);
    if (op == 1 || (op >= 3 && op <= 6)) return 4;
    if (op == 2 || op == 7) return 3;
    return 2;
  endfunction

  function automatic int exp_sel(input int op);
    case (op)
      4: return 1;
      5: return 2;
      6: return 3;
      7: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic reset_dut();
    rst      = 1'b1;
    do_load  = 1'b1;
    stall_en = 1'b0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    do_load = 1'b0;
    ref_mem = init_mem;
    ref_a   = init_a;
    ref_pc  = 4'd0;
    ref_illegal = 1'b0;
  endtask

  task automatic run_prog(input int nret);
    int cyc_in = 0, waits = 0, cnt_a = 0, cnt_b = 0, cnt_w = 0, retired = 0, op = 0, cur;
    bit pend_a = 0, pend_halt = 0, prev_wait = 0, finished = 0;
    logic [3:0] prev_addr = 4'd0;
    logic [7:0] instr;
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pend_a) begin
        check("acc", 32'(a_reg), 32'(ref_a));
        check("illegal", 32'(illegal), 32'(ref_illegal));
        pend_a = 0;
        if (pend_halt) begin
          check("halted", 32'(halted), 32'd1);
          check("halt_req", 32'(mem_bus.mem_req), 32'd0);
        end
        if (pend_halt || retired >= nret) begin
          finished = 1;
          break;
        end
      end
      cyc_in++;
      if (prev_wait && mem_bus.mem_req)
        check("hold_addr", 32'(mem_bus.mem_addr), 32'(prev_addr));
      prev_wait = mem_bus.mem_req && !mem_bus.mem_ready;
      prev_addr = mem_bus.mem_addr;
      if (mem_bus.mem_req && !mem_bus.mem_ready) waits++;
      if (mem_bus.mem_req) check("memwrite", 32'(memWrite), 32'(mem_bus.mem_we));
      if (loadA) begin
        cnt_a++;
        instr = ref_mem[ref_pc];
        cur   = int'(instr[7:4]);
        check("a_src", 32'(a_src), (cur == 1) ? 32'd0 : 32'd1);
        if (cur != 1) check("alusel", 32'(aluSel), 32'(exp_sel(cur)));
      end
      if (loadB) cnt_b++;
      if (memWrite && mem_bus.mem_ready) cnt_w++;
      if (retire) begin
        instr = ref_mem[ref_pc];
        ref_step(op);
        check("latency", 32'(cyc_in), 32'(base_lat(op) + waits));
        check("pc", 32'(pc), 32'(ref_pc));
        check("ir", 32'(ir), 32'(instr));
        check("loada_cnt", 32'(cnt_a), (op == 1 || (op >= 3 && op <= 7)) ? 32'd1 : 32'd0);
        check("loadb_cnt", 32'(cnt_b), (op == 1 || (op >= 3 && op <= 6)) ? 32'd1 : 32'd0);
        check("write_cnt", 32'(cnt_w), (op == 2) ? 32'd1 : 32'd0);
        retired++;
        cyc_in = 0; waits = 0; cnt_a = 0; cnt_b = 0; cnt_w = 0;
        pend_a = 1;
        if (op == 15) pend_halt = 1;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
    for (int i = 0; i < 16; i++) check("mem", 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic halt_probe();
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("halt_start_req", 32'(mem_bus.mem_req), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) init_mem[i] = 8'h00;
  endtask

  int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 1, 3, 15, 11};

  initial begin
    logic [3:0] opv;
    bit found;
    rst = 1'b1; start = 1'b0; do_load = 1'b1; stall_en = 1'b0; stall_addr = 4'd0;
    wait_min = 0; wait_max = 0; init_a = 8'h00;
    clear_prog();
    reset_dut();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_strobes", {27'd0, loadA, loadB, memWrite, retire, a_src}, 32'd0);
    check("rst_alusel", 32'(aluSel), 32'd0);

    // LOAD 5, zero wait
    clear_prog(); init_mem[0] = 8'h15; init_mem[5] = 8'h2A; init_mem[1] = 8'hF0;
    reset_dut(); run_prog(10); halt_probe();

    // ADD 6 with two wait cycles per request
    clear_prog(); init_mem[0] = 8'h36; init_mem[6] = 8'h05; init_mem[1] = 8'hF0;
    init_a = 8'h11; wait_min = 2; wait_max = 2;
    reset_dut(); run_prog(10);

    // STORE 9 with random waits
    clear_prog(); init_mem[0] = 8'h29; init_mem[1] = 8'hF0;
    init_a = 8'h5C; wait_min = 0; wait_max = 3;
    reset_dut(); run_prog(10);

    // NOT, undefined opcode, HALT
    clear_prog(); init_mem[0] = 8'h70; init_mem[1] = 8'h93; init_mem[2] = 8'hF0;
    wait_min = 0; wait_max = 0;
    reset_dut(); run_prog(10); halt_probe();

    // PC wrap through sixteen NOPs
    clear_prog();
    reset_dut(); run_prog(18);

    // Asynchronous reset while OPERAND is stalled
    clear_prog(); init_mem[0] = 8'h15; init_mem[5] = 8'h2A;
    reset_dut();
    stall_en = 1'b1; stall_addr = 4'd5; start = 1'b1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_bus.mem_req && mem_bus.mem_addr == 4'd5) found = 1;
    end
    check("reach_operand", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", 32'(mem_bus.mem_req), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_ir", 32'(ir), 32'd0);
    check("midrst_loadb", 32'(loadB), 32'd0);
    @(negedge clk);
    rst = 1'b0; stall_en = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_idle", 32'(mem_bus.mem_req), 32'd0);

    // Random programs against the reference model
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 16; i++) begin
        opv = 4'(ops[$urandom_range(11, 0)]);
        init_mem[i] = {opv, 4'($urandom_range(15, 0))};
      end
      init_a = 8'($urandom_range(255, 0));
      wait_min = 0; wait_max = 3;
      reset_dut(); run_prog(30);
      if (halted) halt_probe();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
